adder_arbiter: RTL and testbench



---
 rtl/adder_arbiter_pkg.sv | 15 +
 rtl/adder.sv | 11 +
 rtl/adder_arbiter_rr_arbiter.sv | 33 +++
 rtl/adder_arbiter.sv | 111 +++++++++++
 tb/tb_adder_arbiter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared types and limits for the adder arbiter
package adder_arbiter_pkg;

    // Sequencer states: IDLE waits for a request, NEG forms -B, EXEC adds, RESP holds the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    // Largest supported requester count.
    localparam int MAX_REQ = 8;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - shared 32-bit combinational adder, result wraps modulo 2^32
// Ports: a, b (operands), sum (a + b, carry discarded)
module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// rtl/adder_arbiter_rr_arbiter.sv - combinational round-robin arbiter
// Ports: req (request vector), last (previous winner), gnt (one-hot winner),
//        id (encoded winner), any (at least one request present)
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    // Search starts just after the previous winner and wraps, so the previous
    // winner is considered last.
    always_comb begin
        int idx;
        idx = 0;
        gnt = '0;
        id  = '0;
        any = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                id       = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sequencer sharing one adder among requesters
// Ports: clock, reset_n (async active-low); req/req_a/req_b/req_sub request side,
//        gnt one-hot grant (combinational, IDLE only); resp_valid/resp_ready/resp_id/
//        resp_result registered response; busy high outside IDLE.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_result,
    input  logic                  resp_ready,
    output logic                  busy
);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("adder_arbiter: NUM_REQ out of range");
    end

    state_t             state;
    logic [ID_W-1:0]    last;
    logic [31:0]        a_reg;
    logic [31:0]        b_reg;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_sum;
    logic [NUM_REQ-1:0] win_gnt;
    logic [ID_W-1:0]    win_id;
    logic               win_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req  (req),
        .last (last),
        .gnt  (win_gnt),
        .id   (win_id),
        .any  (win_any)
    );

    // Grants are only offered while idle; the arbiter result is ignored otherwise.
    assign gnt = (state == IDLE) ? win_gnt : '0;

    // NEG forms the two's complement of B in place (~B + 1), so EXEC is a plain add
    // for both operations.
    always_comb begin
        add_a = a_reg;
        add_b = b_reg;
        if (state == NEG) begin
            add_a = ~b_reg;
            add_b = 32'd1;
        end
    end

    adder u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last        <= ID_W'(NUM_REQ - 1);
            a_reg       <= '0;
            b_reg       <= '0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        a_reg   <= req_a[32*int'(win_id) +: 32];
                        b_reg   <= req_b[32*int'(win_id) +: 32];
                        resp_id <= win_id;
                        last    <= win_id;
                        busy    <= 1'b1;
                        state   <= req_sub[win_id] ? NEG : EXEC;
                    end
                end
                NEG: begin
                    b_reg <= add_sum;
                    state <= EXEC;
                end
                EXEC: begin
                    resp_result <= add_sum;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]   req_sub = '0;
    logic [N-1:0]   gnt;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [31:0]    resp_result;
    logic           resp_ready = 1'b1;
    logic           busy;

    int checks = 0;
    int failures = 0;

    adder_arbiter #(.NUM_REQ(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sub     (req_sub),
        .gnt         (gnt),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_ready  (resp_ready),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_sub[r]        = s;
    endtask

    // Waits (bounded) for resp_valid; returns cycles elapsed since the call.
    task automatic wait_valid(output int n);
        n = 0;
        while (!resp_valid && n < 12) begin
            tick();
            n++;
        end
    endtask

    // Single op from an idle, uncontended start; called at edge+1 (cycle 0).
    task automatic run_op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int lat, input logic [31:0] expv);
        int n;
        set_ops(r, a, b, s);
        req[r] = 1'b1;
        #1;
        check({tag, "_gnt"}, 32'(gnt), 32'(1 << r));
        tick();
        req[r] = 1'b0;
        wait_valid(n);
        check({tag, "_latency"}, 32'(n + 1), 32'(lat));
        check({tag, "_id"}, 32'(resp_id), 32'(r));
        check({tag, "_result"}, resp_result, expv);
        tick();
        check({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int gi[8];
        int gc[8];
        int k;
        int n;

        // Reset state
        do_reset();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", resp_result, 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);

        // Basic operations
        run_op("add", 0, 32'd5, 32'd7, 1'b0, 2, 32'd12);
        run_op("sub", 2, 32'd3, 32'd5, 1'b1, 3, 32'hFFFF_FFFE);
        run_op("sub_b0", 2, 32'd9, 32'd0, 1'b1, 3, 32'd9);
        run_op("wrap", 1, 32'hFFFF_FFFF, 32'd1, 1'b0, 2, 32'd0);

        // Fairness: all requesting, consumer always ready
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, 32'(10 * i), 32'(i), 1'b0);
        req = '1;
        k = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (gnt != '0 && k < 8) begin
                for (int i = 0; i < N; i++) if (gnt[i]) gi[k] = i;
                gc[k] = c;
                k++;
            end
            tick();
        end
        req = '0;
        check("fair_count", 32'(k), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fair_order%0d", i), 32'(gi[i]), 32'(i % N));
            check($sformatf("fair_cycle%0d", i), 32'(gc[i]), 32'(3 * i));
        end
        repeat (4) tick();

        // Backpressure: last winner is 0, so 1 beats 3
        resp_ready = 1'b0;
        set_ops(1, 32'd100, 32'd23, 1'b0);
        set_ops(3, 32'd7, 32'd8, 1'b1);
        req[1] = 1'b1;
        req[3] = 1'b1;
        #1;
        check("bp_gnt", 32'(gnt), 32'b0010);
        tick();
        req[1] = 1'b0;
        wait_valid(n);
        check("bp_valid", 32'(resp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_hold_result%0d", c), resp_result, 32'd123);
            check($sformatf("bp_hold_id%0d", c), 32'(resp_id), 32'd1);
            check($sformatf("bp_hold_gnt%0d", c), 32'(gnt), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("bp_next_gnt", 32'(gnt), 32'b1000);
        tick();
        req[3] = 1'b0;
        wait_valid(n);
        check("bp_next_id", 32'(resp_id), 32'd3);
        check("bp_next_result", resp_result, 32'hFFFF_FFFF);
        repeat (2) tick();

        // Reset during EXEC: winner pointer must return to NUM_REQ-1
        run_op("pre", 1, 32'd1, 32'd1, 1'b0, 2, 32'd2);
        set_ops(2, 32'd4, 32'd4, 1'b0);
        req[2] = 1'b1;
        #1;
        check("rx_gnt", 32'(gnt), 32'b0100);
        tick();
        req[2] = 1'b0;
        check("rx_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rx_busy_reset", 32'(busy), 32'd0);
        check("rx_valid_reset", 32'(resp_valid), 32'd0);
        #1;
        reset_n = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rx_no_valid%0d", c), 32'(resp_valid), 32'd0);
            tick();
        end
        set_ops(0, 32'd20, 32'd22, 1'b0);
        set_ops(3, 32'd1, 32'd2, 1'b0);
        req[0] = 1'b1;
        req[3] = 1'b1;
        #1;
        check("rx_next_gnt", 32'(gnt), 32'b0001);
        tick();
        req = '0;
        wait_valid(n);
        check("rx_next_id", 32'(resp_id), 32'd0);
        check("rx_next_result", resp_result, 32'd42);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
